gf180mcu_osu_sc_9t_buf_pipe: RTL and testbench



---
 rtl/gf180mcu_osu_sc_9t_buf_pipe.sv | 73 +++++++
 tb/tb_gf180mcu_osu_sc_9t_buf_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_osu_sc_9t_buf_pipe.sv
// Elastic WIDTH x DEPTH registered buffer with valid/ready on both sides,
// circular storage, occupancy output and synchronous flush.
module gf180mcu_osu_sc_9t_buf_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic [WIDTH-1:0] A,
  input  logic             A_VALID,
  output logic             A_READY,
  output logic [WIDTH-1:0] Y,
  output logic             Y_VALID,
  input  logic             Y_READY,
  input  logic             FLUSH,
  output logic [CW-1:0]    COUNT
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic             w_push;
  logic             w_pop;

  // Explicit wrap so non-power-of-two depths stay in range.
  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A_READY depends only on registered occupancy and FLUSH, never on Y_READY.
  assign A_READY = (r_count < CW'(DEPTH)) && !FLUSH;
  assign Y_VALID = (r_count != '0);
  assign Y       = r_mem[r_rptr];
  assign COUNT   = r_count;

  assign w_push  = A_VALID && A_READY;
  assign w_pop   = Y_VALID && Y_READY && !FLUSH;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (FLUSH) begin
      // Storage is deliberately left untouched; only the bookkeeping clears.
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= A;
        r_wptr        <= f_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= f_inc(r_rptr);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gf180mcu_osu_sc_9t_buf_pipe.sv
// Scoreboard bench for the elastic buffer: DEPTH=4 instance for the directed
// scenarios, DEPTH=3 instance for pointer wrap with backpressure.
module tb_gf180mcu_osu_sc_9t_buf_pipe;

  logic       clk;
  logic       rn;

  logic [7:0] a4, y4;
  logic       av4, ar4, yv4, yr4, fl4;
  logic [2:0] cnt4;

  logic [7:0] a3, y3;
  logic       av3, ar3, yv3, yr3, fl3;
  logic [1:0] cnt3;

  int n_checks = 0;
  int n_errors = 0;
  int pops3    = 0;

  logic [7:0] q4[$];
  logic [7:0] q3[$];

  gf180mcu_osu_sc_9t_buf_pipe #(.WIDTH(8), .DEPTH(4)) u_dut4 (
    .CLK(clk), .RN(rn), .A(a4), .A_VALID(av4), .A_READY(ar4),
    .Y(y4), .Y_VALID(yv4), .Y_READY(yr4), .FLUSH(fl4), .COUNT(cnt4)
  );

  gf180mcu_osu_sc_9t_buf_pipe #(.WIDTH(8), .DEPTH(3)) u_dut3 (
    .CLK(clk), .RN(rn), .A(a3), .A_VALID(av3), .A_READY(ar3),
    .Y(y3), .Y_VALID(yv3), .Y_READY(yr3), .FLUSH(fl3), .COUNT(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: a transfer is committed at the next rising edge when valid,
  // ready and no flush are all seen on the falling edge before it.
  always @(negedge clk) begin
    if (rn && yv4 && yr4 && !fl4) begin
      n_checks++;
      if (q4.size() == 0) begin
        n_errors++;
        $display("FAIL y4_unexpected: got 0x%0h with empty scoreboard at %0t", y4, $time);
      end else begin
        logic [7:0] e;
        e = q4.pop_front();
        if (y4 !== e) begin
          n_errors++;
          $display("FAIL y4_data: got 0x%0h expected 0x%0h at %0t", y4, e, $time);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rn && yv3 && yr3 && !fl3) begin
      n_checks++;
      pops3++;
      if (q3.size() == 0) begin
        n_errors++;
        $display("FAIL y3_unexpected: got 0x%0h with empty scoreboard at %0t", y3, $time);
      end else begin
        logic [7:0] e;
        e = q3.pop_front();
        if (y3 !== e) begin
          n_errors++;
          $display("FAIL y3_data: got 0x%0h expected 0x%0h at %0t", y3, e, $time);
        end
      end
    end
  end

  logic [7:0]  wrap_data [10] = '{8'h3A, 8'h5C, 8'h7E, 8'h91, 8'hB3,
                                  8'hD5, 8'hF7, 8'h19, 8'h2B, 8'h4D};
  logic [15:0] bp_pat = 16'b1011_0010_1101_0110;

  initial begin
    rn = 1'b0;
    a4 = '0; av4 = 0; yr4 = 0; fl4 = 0;
    a3 = '0; av3 = 0; yr3 = 0; fl3 = 0;

    // Reset
    repeat (3) tick();
    rn = 1'b1;
    #2;
    chk("rst_y", y4, 8'h00);
    chk("rst_yvalid", yv4, 1'b0);
    chk("rst_aready", ar4, 1'b1);
    chk("rst_count", cnt4, 3'd0);
    tick();

    // Fill with no consumer, then drain
    av4 = 1;
    for (int i = 0; i < 4; i++) begin
      a4 = 8'(8'h11 * (i + 1));
      q4.push_back(a4);
      tick();
    end
    chk("full_count", cnt4, 3'd4);
    chk("full_aready", ar4, 1'b0);
    a4 = 8'h55;
    tick();
    chk("full_ignore_count", cnt4, 3'd4);
    av4 = 0;
    yr4 = 1;
    repeat (4) tick();
    chk("drain_yvalid", yv4, 1'b0);
    chk("drain_count", cnt4, 3'd0);
    chk("empty_y_holds", y4, 8'h11);
    yr4 = 0;
    tick();

    // Streaming at one transfer per cycle
    yr4 = 1;
    av4 = 1;
    for (int i = 0; i < 16; i++) begin
      a4 = 8'(i);
      q4.push_back(a4);
      tick();
      chk("stream_yvalid", yv4, 1'b1);
      chk("stream_count", cnt4, 3'd1);
    end
    av4 = 0;
    tick();
    chk("stream_end_count", cnt4, 3'd0);
    yr4 = 0;
    tick();

    // Full with simultaneous pop: pop wins, push waits a cycle
    av4 = 1;
    for (int i = 0; i < 4; i++) begin
      a4 = 8'(8'hC1 + i);
      q4.push_back(a4);
      tick();
    end
    chk("fp_count4", cnt4, 3'd4);
    a4 = 8'hC5;
    q4.push_back(a4);
    yr4 = 1;
    #1;
    chk("fp_aready_full", ar4, 1'b0);
    tick();
    chk("fp_count3", cnt4, 3'd3);
    yr4 = 0;
    tick();
    chk("fp_count_refill", cnt4, 3'd4);
    av4 = 0;
    yr4 = 1;
    repeat (4) tick();
    chk("fp_drained", cnt4, 3'd0);
    yr4 = 0;

    // Flush drops contents and suppresses that edge's transfers
    av4 = 1;
    a4 = 8'hD1; q4.push_back(a4); tick();
    a4 = 8'hD2; q4.push_back(a4); tick();
    av4 = 0;
    chk("fl_pre_count", cnt4, 3'd2);
    fl4 = 1; av4 = 1; a4 = 8'hEE; yr4 = 1;
    #1;
    chk("fl_aready", ar4, 1'b0);
    tick();
    fl4 = 0; av4 = 0; yr4 = 0;
    q4.delete();
    chk("fl_count", cnt4, 3'd0);
    chk("fl_yvalid", yv4, 1'b0);
    a4 = 8'hA5; av4 = 1; q4.push_back(a4);
    tick();
    av4 = 0;
    chk("fl_post_yvalid", yv4, 1'b1);
    chk("fl_post_y", y4, 8'hA5);
    yr4 = 1;
    tick();
    yr4 = 0;
    tick();

    // Asynchronous reset mid-cycle with three entries held
    av4 = 1;
    for (int i = 0; i < 3; i++) begin
      a4 = 8'(8'h61 + i);
      q4.push_back(a4);
      tick();
    end
    av4 = 0;
    chk("ar_pre_count", cnt4, 3'd3);
    #2;
    rn = 1'b0;
    #1;
    chk("ar_count", cnt4, 3'd0);
    chk("ar_yvalid", yv4, 1'b0);
    chk("ar_y", y4, 8'h00);
    q4.delete();
    tick();
    rn = 1'b1;
    tick();

    // DEPTH=3 wrap with table-driven backpressure
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          int budget;
          a3 = wrap_data[i];
          av3 = 1;
          q3.push_back(a3);
          budget = 0;
          while (!ar3 && budget < 50) begin
            tick();
            budget++;
          end
          if (!ar3) begin
            n_checks++;
            n_errors++;
            $display("FAIL wrap_push_timeout: got ready 0 expected 1 at %0t", $time);
          end
          tick();
        end
        av3 = 0;
      end
      begin
        int cyc;
        cyc = 0;
        while (pops3 < 10 && cyc < 300) begin
          yr3 = bp_pat[cyc % 16];
          tick();
          cyc++;
        end
        yr3 = 0;
      end
    join
    chk("wrap_pops", 32'(pops3), 32'd10);
    chk("wrap_count", cnt3, 2'd0);
    chk("wrap_q_empty", 32'(q3.size()), 32'd0);
    chk("q4_empty", 32'(q4.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
